shot_sequencer: RTL and testbench

//  Turn-level controller around the collision/physics datapath (hit_controller, ball movers).

---
 rtl/billiard_pkg.sv | 30 +++
 rtl/rest_detector.sv | 49 ++++
 rtl/shot_sequencer.sv | 118 +++++++++++
 tb/tb_shot_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/billiard_pkg.sv
// Shared types and defaults for the billiard turn controller and its helpers.
// Velocities are 11-bit two's complement, matching the ball mover datapath.
package billiard_pkg;

    typedef enum logic [2:0] {
        AIM    = 3'd0,
        FIRE   = 3'd1,
        ROLL   = 3'd2,
        SETTLE = 3'd3,
        OVER   = 3'd4
    } shot_state_t;

    typedef logic signed [10:0] vel_t;

    localparam int MAX_VEL_DEF     = 64;
    localparam int STOP_FRAMES_DEF = 4;
    localparam int MAX_SHOTS_DEF   = 15;

    // Symmetric signed clamp of one velocity component to +/-lim.
    function automatic vel_t clamp_vel(input vel_t v, input int lim);
        vel_t hi;
        vel_t lo;
        hi = vel_t'(lim);
        lo = vel_t'(-lim);
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/rest_detector.sv
// Counts consecutive frames with both balls stationary; the first frame after
// a clear is skipped because the white mover picks up its cue velocity late.
module rest_detector
    import billiard_pkg::*;
#(
    parameter int STOP_FRAMES = STOP_FRAMES_DEF
) (
    input  logic clk,
    input  logic resetN,
    input  vel_t whiteVelX,
    input  vel_t whiteVelY,
    input  vel_t redVelX,
    input  vel_t redVelY,
    input  logic startOfFrame,
    input  logic clear,
    output logic atRest
);

    localparam int CW = $clog2(STOP_FRAMES + 1);
    localparam logic [CW-1:0] STOP_CNT = CW'(STOP_FRAMES);

    logic [CW-1:0] rest_cnt;
    logic          skip_frame;
    logic          all_zero;

    assign all_zero = (whiteVelX == '0) && (whiteVelY == '0) &&
                      (redVelX == '0)   && (redVelY == '0);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rest_cnt   <= '0;
            skip_frame <= 1'b1;
        end else if (clear) begin
            rest_cnt   <= '0;
            skip_frame <= 1'b1;
        end else if (startOfFrame) begin
            if (skip_frame)
                skip_frame <= 1'b0;
            else if (!all_zero)
                rest_cnt <= '0;
            else if (rest_cnt != STOP_CNT)
                rest_cnt <= rest_cnt + CW'(1);
        end
    end

    assign atRest = (rest_cnt == STOP_CNT);

endmodule

// File: rtl/shot_sequencer.sv
// Turn-level controller: aim, fire clamped cue velocity, roll until rest,
// settle pockets into score/respawns, and end the game after the last shot.
module shot_sequencer
    import billiard_pkg::*;
#(
    parameter int STOP_FRAMES = STOP_FRAMES_DEF,
    parameter int MAX_SHOTS   = MAX_SHOTS_DEF,
    parameter int MAX_VEL     = MAX_VEL_DEF
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       shotReq,
    input  vel_t       cueVelX,
    input  vel_t       cueVelY,
    input  vel_t       whiteBallVelX,
    input  vel_t       whiteBallVelY,
    input  vel_t       redBallVelX,
    input  vel_t       redBallVelY,
    input  logic       whiteBallHoleHit,
    input  logic       redBallHoleHit,
    output logic       aimEnable,
    output logic       loadCueVel,
    output vel_t       cueVelXOut,
    output vel_t       cueVelYOut,
    output logic       motionEnable,
    output logic       respawnWhite,
    output logic       respawnRed,
    output logic [7:0] score,
    output logic [3:0] shotsLeft,
    output logic       gameOver,
    output logic [2:0] stateDbg
);

    shot_state_t state, next_state;
    logic        shot_req_q;
    logic        white_potted, red_potted;
    logic        at_rest;
    logic        shot_rise, pot_white, pot_red, settle_go;
    logic [7:0]  score_next;

    assign shot_rise = shotReq & ~shot_req_q;
    // Include this cycle's hit so a pot coinciding with the final rest frame counts.
    assign pot_white = white_potted | whiteBallHoleHit;
    assign pot_red   = red_potted | redBallHoleHit;

    rest_detector #(.STOP_FRAMES(STOP_FRAMES)) u_rest (
        .clk         (clk),
        .resetN      (resetN),
        .whiteVelX   (whiteBallVelX),
        .whiteVelY   (whiteBallVelY),
        .redVelX     (redBallVelX),
        .redVelY     (redBallVelY),
        .startOfFrame(startOfFrame),
        .clear       (state != ROLL),
        .atRest      (at_rest)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        score_next = score;
        unique case (state)
            AIM:     if (shot_rise && shotsLeft != 4'd0) next_state = FIRE;
            FIRE:    next_state = ROLL;
            ROLL:    if (at_rest) next_state = SETTLE;
            SETTLE:  next_state = (shotsLeft == 4'd0) ? OVER : AIM;
            OVER:    next_state = OVER;
            default: next_state = AIM;
        endcase
        settle_go = (state == ROLL) && (next_state == SETTLE);
        if (settle_go) begin
            if (pot_red && !pot_white && score != 8'hFF)
                score_next = score + 8'd1;
            else if (pot_white && !pot_red && score != 8'h00)
                score_next = score - 8'd1;
        end
    end

    // Outputs are decoded from next_state so they are registered yet line up with state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= AIM;
            shot_req_q   <= 1'b0;
            white_potted <= 1'b0;
            red_potted   <= 1'b0;
            aimEnable    <= 1'b1;
            loadCueVel   <= 1'b0;
            cueVelXOut   <= '0;
            cueVelYOut   <= '0;
            motionEnable <= 1'b0;
            respawnWhite <= 1'b0;
            respawnRed   <= 1'b0;
            score        <= 8'd0;
            shotsLeft    <= 4'(MAX_SHOTS);
            gameOver     <= 1'b0;
        end else begin
            state        <= next_state;
            shot_req_q   <= shotReq;
            white_potted <= (state == ROLL) ? pot_white : 1'b0;
            red_potted   <= (state == ROLL) ? pot_red : 1'b0;
            aimEnable    <= (next_state == AIM);
            loadCueVel   <= (next_state == FIRE);
            cueVelXOut   <= (next_state == FIRE) ? clamp_vel(cueVelX, MAX_VEL) : '0;
            cueVelYOut   <= (next_state == FIRE) ? clamp_vel(cueVelY, MAX_VEL) : '0;
            motionEnable <= (next_state == ROLL);
            respawnWhite <= settle_go & pot_white;
            respawnRed   <= settle_go & pot_red;
            score        <= score_next;
            if (state == AIM && next_state == FIRE)
                shotsLeft <= shotsLeft - 4'd1;
            gameOver     <= (next_state == OVER);
        end
    end

    assign stateDbg = state;

endmodule

// File: tb/tb_shot_sequencer.sv
// Self-checking bench for shot_sequencer: directed shots plus a randomized game,
// compared against a frame-level model of the turn rules.
module tb_shot_sequencer;
    import billiard_pkg::*;

    localparam int SHOTS = 15;
    localparam int VMAX  = 64;

    typedef struct {
        vel_t wx, wy, rx, ry;
    } frame_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame, shotReq;
    vel_t       cueVelX, cueVelY;
    vel_t       whiteBallVelX, whiteBallVelY, redBallVelX, redBallVelY;
    logic       whiteBallHoleHit, redBallHoleHit;
    logic       aimEnable, loadCueVel, motionEnable, respawnWhite, respawnRed, gameOver;
    vel_t       cueVelXOut, cueVelYOut;
    logic [7:0] score;
    logic [3:0] shotsLeft;
    logic [2:0] stateDbg;

    int ntotal = 0;
    int npass  = 0;
    int model_score;
    int model_shots;
    frame_t plan[$];

    always #5 clk = ~clk;

    shot_sequencer dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .shotReq(shotReq),
        .cueVelX(cueVelX), .cueVelY(cueVelY),
        .whiteBallVelX(whiteBallVelX), .whiteBallVelY(whiteBallVelY),
        .redBallVelX(redBallVelX), .redBallVelY(redBallVelY),
        .whiteBallHoleHit(whiteBallHoleHit), .redBallHoleHit(redBallHoleHit),
        .aimEnable(aimEnable), .loadCueVel(loadCueVel),
        .cueVelXOut(cueVelXOut), .cueVelYOut(cueVelYOut),
        .motionEnable(motionEnable), .respawnWhite(respawnWhite), .respawnRed(respawnRed),
        .score(score), .shotsLeft(shotsLeft), .gameOver(gameOver), .stateDbg(stateDbg)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_clamp(input int v);
        if (v > VMAX)  return VMAX;
        if (v < -VMAX) return -VMAX;
        return v;
    endfunction

    function automatic bit is_still(input frame_t f);
        return f.wx == 0 && f.wy == 0 && f.rx == 0 && f.ry == 0;
    endfunction

    function automatic frame_t rand_frame(input int idx);
        frame_t f;
        int     v;
        f = '{0, 0, 0, 0};
        if (idx < 30 && $urandom_range(0, 99) < 30) begin
            v = int'($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 1) v = -v;
            case ($urandom_range(0, 3))
                0: f.wx = vel_t'(v);
                1: f.wy = vel_t'(v);
                2: f.rx = vel_t'(v);
                default: f.ry = vel_t'(v);
            endcase
        end
        return f;
    endfunction

    task automatic check_reset_values(input string p);
        check({p, "_state"}, stateDbg, AIM);
        check({p, "_aim"}, aimEnable, 1);
        check({p, "_load"}, loadCueVel, 0);
        check({p, "_cuex"}, cueVelXOut, 0);
        check({p, "_cuey"}, cueVelYOut, 0);
        check({p, "_motion"}, motionEnable, 0);
        check({p, "_resp_w"}, respawnWhite, 0);
        check({p, "_resp_r"}, respawnRed, 0);
        check({p, "_score"}, score, 0);
        check({p, "_shots"}, shotsLeft, SHOTS);
        check({p, "_over"}, gameOver, 0);
    endtask

    task automatic shot(input int cx, input int cy, input bit hw_mid, input bit hr_mid,
                        input bit hw_last, input bit hr_last, input bit reset_mid);
        int                 pulses, cnt, idx;
        logic signed [31:0] got_x, got_y;
        bit                 pw, pr, final_f;
        frame_t             f;

        check("aim_state", stateDbg, AIM);
        check("aim_enable", aimEnable, 1);
        // Pocket hits while aiming must not be remembered.
        whiteBallHoleHit = 1'b1;
        redBallHoleHit   = 1'b1;
        step();
        whiteBallHoleHit = 1'b0;
        redBallHoleHit   = 1'b0;

        cueVelX = vel_t'(cx);
        cueVelY = vel_t'(cy);
        shotReq = 1'b1;
        pulses  = 0;
        got_x   = 'x;
        got_y   = 'x;
        for (int i = 0; i < 10; i++) begin
            step();
            if (loadCueVel) begin
                pulses++;
                got_x = cueVelXOut;
                got_y = cueVelYOut;
            end
        end
        shotReq = 1'b0;
        model_shots--;
        check("load_pulses", pulses, 1);
        check("cue_x", got_x, ref_clamp(cx));
        check("cue_y", got_y, ref_clamp(cy));
        check("cue_x_idle", cueVelXOut, 0);
        check("shots_left", shotsLeft, model_shots);
        check("roll_motion", motionEnable, 1);
        check("roll_aim", aimEnable, 0);

        pw = 0; pr = 0; cnt = 0; idx = 0; final_f = 0;
        while (!final_f && idx < 60) begin
            f = (plan.size() > 0) ? plan.pop_front() : rand_frame(idx);
            if (idx > 0) begin
                cnt     = is_still(f) ? cnt + 1 : 0;
                final_f = (cnt == 4);
            end
            whiteBallVelX = f.wx; whiteBallVelY = f.wy;
            redBallVelX   = f.rx; redBallVelY   = f.ry;
            startOfFrame  = 1'b1;
            if (idx == 1) begin whiteBallHoleHit = hw_mid;  redBallHoleHit = hr_mid;  end
            if (final_f)  begin whiteBallHoleHit = hw_last; redBallHoleHit = hr_last; end
            pw |= whiteBallHoleHit;
            pr |= redBallHoleHit;
            step();
            startOfFrame     = 1'b0;
            whiteBallHoleHit = 1'b0;
            redBallHoleHit   = 1'b0;
            if (reset_mid && idx == 2) begin
                resetN = 1'b0;
                #1;
                check_reset_values("mid_reset");
                @(negedge clk);
                resetN = 1'b1;
                step();
                check("post_reset_resp_w", respawnWhite, 0);
                check("post_reset_resp_r", respawnRed, 0);
                check("post_reset_state", stateDbg, AIM);
                model_score = 0;
                model_shots = SHOTS;
                return;
            end
            step();
            if (!final_f) check("roll_hold", stateDbg, ROLL);
            idx++;
        end

        if (pr && !pw && model_score < 255) model_score++;
        else if (pw && !pr && model_score > 0) model_score--;
        check("settle_state", stateDbg, SETTLE);
        check("settle_motion", motionEnable, 0);
        check("respawn_w", respawnWhite, pw);
        check("respawn_r", respawnRed, pr);
        check("score", score, model_score);
        step();
        check("respawn_w_end", respawnWhite, 0);
        check("respawn_r_end", respawnRed, 0);
        check("post_state", stateDbg, (model_shots == 0) ? OVER : AIM);
        check("game_over", gameOver, (model_shots == 0) ? 1 : 0);
    endtask

    initial begin
        int pulses;
        resetN = 1'b0;
        startOfFrame = 1'b0; shotReq = 1'b0;
        cueVelX = '0; cueVelY = '0;
        whiteBallVelX = '0; whiteBallVelY = '0; redBallVelX = '0; redBallVelY = '0;
        whiteBallHoleHit = 1'b0; redBallHoleHit = 1'b0;
        model_score = 0;
        model_shots = SHOTS;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        resetN = 1'b1;
        step();

        // Skipped frame, three still frames, red moves, then four still frames.
        plan.push_back('{0, 0, 0, 0});
        for (int i = 0; i < 3; i++) plan.push_back('{0, 0, 0, 0});
        plan.push_back('{0, 0, 5, 0});
        for (int i = 0; i < 4; i++) plan.push_back('{0, 0, 0, 0});
        shot(30, -20, 0, 1, 0, 0, 0);
        shot(200, -300, 1, 0, 0, 0, 0);
        shot(-1024, 64, 1, 0, 0, 1, 0);
        shot(-64, 1023, 0, 0, 1, 0, 0);
        shot(63, -65, 0, 0, 0, 1, 0);
        shot(5, 5, 0, 1, 0, 0, 1);

        for (int s = 0; s < SHOTS; s++)
            shot(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 0);

        shotReq = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (loadCueVel) pulses++;
            if (i == 2) shotReq = 1'b0;
            if (i == 3) shotReq = 1'b1;
        end
        shotReq = 1'b0;
        check("over_no_fire", pulses, 0);
        check("over_state", stateDbg, OVER);
        check("over_flag", gameOver, 1);
        check("over_shots", shotsLeft, 0);
        check("over_aim", aimEnable, 0);
        check("over_motion", motionEnable, 0);
        check("over_score", score, model_score);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
